// File: rtl/rv32i_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues in-order memory requests, buffers words in a prefetch queue.
// Define FETCH_MISALIGN_TRAP_EN to reject misaligned redirects and pulse fetch_misaligned instead.
module rv32i_fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              QUEUE_DEPTH  = 4
) (
  input  logic            pll_1_200MHz,
  input  logic            system_reset,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [31:0]     fetch_instruction,
  output logic [XLEN-1:0] fetch_pc
`ifdef FETCH_MISALIGN_TRAP_EN
  ,output logic           fetch_misaligned
`endif
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_shadow;
  logic [31:0]     r_q_instr [QUEUE_DEPTH];
  logic [XLEN-1:0] r_q_pc    [QUEUE_DEPTH];
  logic [PW-1:0]   r_rd_ptr;
  logic [PW-1:0]   r_wr_ptr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_drop;

  logic [CW-1:0]   w_used;
  logic            w_has_credit;
  logic            w_redirect;
  logic [XLEN-1:0] w_target;
  logic            w_req_fire;
  logic            w_push;
  logic            w_pop;
  logic            w_not_empty;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic w_misaligned;
  logic r_misaligned;

  assign w_misaligned     = redirect_valid && (redirect_target[1:0] != 2'b00);
  assign w_redirect       = redirect_valid && !w_misaligned;
  assign w_target         = redirect_target;
  assign fetch_misaligned = r_misaligned;

  always_ff @(posedge pll_1_200MHz) begin
    if (system_reset) r_misaligned <= 1'b0;
    else              r_misaligned <= w_misaligned;
  end
`else
  assign w_redirect = redirect_valid;
  assign w_target   = redirect_target & ~XLEN'(3);
`endif

  // Credits count queue slots not yet claimed by a stored word or an outstanding request.
  assign w_used       = r_count + r_inflight;
  assign w_has_credit = w_used < CW'(QUEUE_DEPTH);

  assign imem_req_valid = !system_reset && w_has_credit && !redirect_valid;
  assign imem_req_addr  = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  assign w_not_empty       = (r_count != '0);
  assign fetch_valid       = w_not_empty && !redirect_valid;
  assign fetch_instruction = w_not_empty ? r_q_instr[r_rd_ptr] : 32'h0;
  assign fetch_pc          = w_not_empty ? r_q_pc[r_rd_ptr] : '0;

  assign w_pop  = fetch_valid && fetch_ready;
  assign w_push = imem_rsp_valid && (r_drop == '0);

  always_ff @(posedge pll_1_200MHz) begin
    if (!system_reset && !w_redirect && w_push) begin
      r_q_instr[r_wr_ptr] <= imem_rsp_data;
      r_q_pc[r_wr_ptr]    <= r_shadow;
    end
  end

  always_ff @(posedge pll_1_200MHz) begin
    if (system_reset) begin
      r_pc       <= RESET_VECTOR;
      r_shadow   <= RESET_VECTOR;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
    end else if (w_redirect) begin
      // Every request still outstanding after this cycle belongs to the old path.
      r_pc       <= w_target;
      r_shadow   <= w_target;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= r_inflight - CW'(imem_rsp_valid);
      r_drop     <= r_inflight - CW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) r_pc <= r_pc + XLEN'(4);
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(imem_rsp_valid);
      if (imem_rsp_valid && (r_drop != '0)) r_drop <= r_drop - CW'(1);
      if (w_push) begin
        r_shadow <= r_shadow + XLEN'(4);
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Directed bench for rv32i_fetch_unit: per-cycle vector table plus hand-written multi-cycle sequences.
module tb_rv32i_fetch_unit;

  logic        clk = 1'b0;
  logic        system_reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'h0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        fetch_valid;
  logic        fetch_ready = 1'b0;
  logic [31:0] fetch_instruction;
  logic [31:0] fetch_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  always #5 clk = ~clk;

  rv32i_fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .QUEUE_DEPTH(4)) dut (
    .pll_1_200MHz      (clk),
    .system_reset      (system_reset),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_rsp_valid    (imem_rsp_valid),
    .imem_rsp_data     (imem_rsp_data),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,.fetch_misaligned (fetch_misaligned)
`endif
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        frdy;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_fpc;
  } vec_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  int          lat   = 1;
  int          n_acc = 0;
  pend_t       pend[$];
  logic [31:0] pop_pc[$];
  logic [31:0] pop_ins[$];
  logic        s_rv, s_fv, s_mis;
  logic [31:0] s_addr, s_fpc, s_fins;
  vec_t        tbl[9];

  function automatic logic [31:0] ins_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic chk_pop(input string name, input int k, input logic [31:0] exp);
    if (pop_pc.size() <= k) begin
      total++;
      bad++;
      $display("FAIL %s: only %0d pops seen, required pc %h at index %0d", name, pop_pc.size(), exp, k);
    end else begin
      chk({name, ".pc"}, pop_pc[k], exp);
      chk({name, ".ins"}, pop_ins[k], ins_of(exp));
    end
  endtask

  // One clock cycle: sample outputs mid-cycle, model memory acceptance, drive next response.
  task automatic step();
    @(negedge clk);
    s_rv   = imem_req_valid;
    s_addr = imem_req_addr;
    s_fv   = fetch_valid;
    s_fpc  = fetch_pc;
    s_fins = fetch_instruction;
`ifdef FETCH_MISALIGN_TRAP_EN
    s_mis  = fetch_misaligned;
`else
    s_mis  = 1'b0;
`endif
    if (!system_reset && imem_req_valid && imem_req_ready) begin
      pend.push_back('{imem_req_addr, cyc + lat});
      n_acc++;
    end
    if (!system_reset && fetch_valid && fetch_ready) begin
      pop_pc.push_back(fetch_pc);
      pop_ins.push_back(fetch_instruction);
      $display("cycle %0d: pop pc=%h ins=%h", cyc, fetch_pc, fetch_instruction);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = ins_of(pend[0].addr);
      pend.delete(0);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  endtask

  task automatic do_reset();
    system_reset   = 1'b1;
    redirect_valid = 1'b0;
    fetch_ready    = 1'b0;
    imem_req_ready = 1'b1;
    repeat (4) step();
    pend.delete();
    pop_pc.delete();
    pop_ins.delete();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    n_acc          = 0;
    cyc            = 0;
    system_reset   = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // redir tgt frdy | exp req_valid, req_addr, fetch_valid, fetch_pc  (1-cycle memory)
    tbl[0] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0000, 1'b0, 32'h0};
    tbl[1] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0004, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0008, 1'b1, 32'h0000_0000};
    tbl[3] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_000C, 1'b1, 32'h0000_0004};
    tbl[4] = '{1'b1, 32'h100, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 32'h0};
    tbl[5] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'h0000_0100};
    tbl[8] = '{1'b0, 32'h0,   1'b1, 1'b1, 32'h0000_010C, 1'b1, 32'h0000_0104};

    lat = 1;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      redirect_valid  = tbl[i].redir;
      redirect_target = tbl[i].tgt;
      fetch_ready     = tbl[i].frdy;
      step();
      $display("vec %0d: req_valid=%b addr=%h fetch_valid=%b fetch_pc=%h", i, s_rv, s_addr, s_fv, s_fpc);
      chk($sformatf("v%0d.req_valid", i), 32'(s_rv), 32'(tbl[i].e_rv));
      if (tbl[i].e_rv) chk($sformatf("v%0d.req_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("v%0d.fetch_valid", i), 32'(s_fv), 32'(tbl[i].e_fv));
      if (tbl[i].e_fv) begin
        chk($sformatf("v%0d.fetch_pc", i), s_fpc, tbl[i].e_fpc);
        chk($sformatf("v%0d.fetch_ins", i), s_fins, ins_of(tbl[i].e_fpc));
      end
      if (i == 0) begin
        chk("reset.fetch_pc", s_fpc, 32'h0);
        chk("reset.fetch_ins", s_fins, 32'h0);
        chk("reset.misaligned", 32'(s_mis), 32'h0);
      end
    end
    redirect_valid = 1'b0;

    // Decode stalled: exactly QUEUE_DEPTH requests, then drain in order.
    lat = 1;
    do_reset();
    fetch_ready = 1'b0;
    repeat (10) step();
    $display("stall: requests accepted=%0d req_valid=%b", n_acc, s_rv);
    chk("stall.req_count", 32'(n_acc), 32'd4);
    chk("stall.req_valid", 32'(s_rv), 32'h0);
    chk("stall.fetch_valid", 32'(s_fv), 32'h1);
    fetch_ready = 1'b1;
    repeat (8) step();
    for (int k = 0; k < 6; k++) chk_pop($sformatf("stall.pop%0d", k), k, 32'(4 * k));

    // 3-cycle memory, redirect with two requests outstanding.
    lat = 3;
    do_reset();
    fetch_ready = 1'b1;
    step();
    step();
    chk("lat3.inflight_reqs", 32'(n_acc), 32'd2);
    redirect_valid  = 1'b1;
    redirect_target = 32'h100;
    step();
    $display("lat3: redirect to %h, req_valid=%b", redirect_target, s_rv);
    chk("lat3.redir_req_valid", 32'(s_rv), 32'h0);
    redirect_valid = 1'b0;
    repeat (10) step();
    chk_pop("lat3.pop0", 0, 32'h100);
    chk_pop("lat3.pop1", 1, 32'h104);
    chk_pop("lat3.pop2", 2, 32'h108);

    // Misaligned redirect target.
    lat = 1;
    do_reset();
    fetch_ready = 1'b1;
    repeat (3) step();
    pop_pc.delete();
    pop_ins.delete();
    redirect_valid  = 1'b1;
    redirect_target = 32'h102;
    step();
    chk("mis.redir_req_valid", 32'(s_rv), 32'h0);
    redirect_valid = 1'b0;
    step();
    $display("mis: after redirect to 102 req_addr=%h misaligned=%b", s_addr, s_mis);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis.req_addr", s_addr, 32'h0000_000C);
    chk("mis.pulse", 32'(s_mis), 32'h1);
    step();
    chk("mis.pulse_end", 32'(s_mis), 32'h0);
    repeat (4) step();
    chk_pop("mis.pop0", 0, 32'h4);
    chk_pop("mis.pop1", 1, 32'h8);
`else
    chk("mis.req_valid", 32'(s_rv), 32'h1);
    chk("mis.req_addr", s_addr, 32'h0000_0100);
    repeat (4) step();
    chk_pop("mis.pop0", 0, 32'h100);
`endif

    // PC wrap at the top of the address space, with a memory back-pressure hold.
    lat = 1;
    do_reset();
    fetch_ready     = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b0;
    step();
    chk("wrap.hold0_valid", 32'(s_rv), 32'h1);
    chk("wrap.hold0_addr", s_addr, 32'hFFFF_FFFC);
    step();
    chk("wrap.hold1_addr", s_addr, 32'hFFFF_FFFC);
    imem_req_ready = 1'b1;
    step();
    chk("wrap.accept_addr", s_addr, 32'hFFFF_FFFC);
    step();
    $display("wrap: next req_addr=%h", s_addr);
    chk("wrap.next_addr", s_addr, 32'h0000_0000);
    repeat (3) step();
    chk_pop("wrap.pop0", 0, 32'hFFFF_FFFC);
    chk_pop("wrap.pop1", 1, 32'h0000_0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
